// File: rtl/input_event_arbiter.sv
// Synchronizes raw button/switch inputs, optionally debounces them (INPUT_EVENT_DEBOUNCE_EN), and queues
// per-channel rising edges that are offered one at a time, round-robin, on an event_valid/event_ready port.
module input_event_arbiter #(
  parameter int  NUM_INPUTS      = 4,
  parameter int  DEBOUNCE_CYCLES = 16,
  localparam int IDW             = $clog2(NUM_INPUTS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] in,
  output logic [NUM_INPUTS-1:0] level,
  output logic                  event_valid,
  output logic [IDW-1:0]        event_id,
  input  logic                  event_ready,
  output logic [NUM_INPUTS-1:0] dropped
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  if (NUM_INPUTS < 2 || NUM_INPUTS > 8) begin : g_bad_num_inputs
    $error("input_event_arbiter: NUM_INPUTS must be in 2..8");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("input_event_arbiter: DEBOUNCE_CYCLES must be in 2..255");
  end

  logic [NUM_INPUTS-1:0] sync1_q, sync2_q;
  logic [NUM_INPUTS-1:0] stable_q, stable_d;
  logic [NUM_INPUTS-1:0] rise;
  logic [NUM_INPUTS-1:0] pending_q, pending_d;
  logic [NUM_INPUTS-1:0] dropped_q, dropped_d;
  logic [NUM_INPUTS-1:0] clr;
  state_t                state_q, state_d;
  logic [IDW-1:0]        event_id_q, event_id_d;
  logic [IDW-1:0]        last_grant_q, last_grant_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

`ifdef INPUT_EVENT_DEBOUNCE_EN
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] cnt_q [NUM_INPUTS];
  logic [7:0] cnt_d [NUM_INPUTS];

  // The counter only runs while the synchronized input disagrees with the accepted level.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cnt_d[i] = 8'd0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (reset) begin
        cnt_q[i] <= 8'd0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  assign stable_d = sync2_q;
`endif

  assign rise = stable_d & ~stable_q;

  // A new edge always wins over the handshake clearing the same bit.
  assign pending_d = (pending_q & ~clr) | rise;
  assign dropped_d = dropped_q | (rise & pending_q & ~clr);

  always_ff @(posedge clock) begin
    if (reset) begin
      stable_q  <= '0;
      pending_q <= '0;
      dropped_q <= '0;
    end else begin
      stable_q  <= stable_d;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
    end
  end

  // Scans from the farthest candidate to the nearest so the nearest pending channel after last wins.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_INPUTS-1:0] req,
                                             input logic [IDW-1:0]        last);
    logic [IDW-1:0] sel;
    int             idx;
    sel = last;
    for (int off = NUM_INPUTS; off >= 1; off--) begin
      idx = (int'(last) + off) % NUM_INPUTS;
      if (req[IDW'(idx)]) begin
        sel = IDW'(idx);
      end
    end
    return sel;
  endfunction

  always_comb begin
    state_d      = state_q;
    event_id_d   = event_id_q;
    last_grant_d = last_grant_q;
    clr          = '0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          event_id_d = rr_pick(pending_q, last_grant_q);
          state_d    = OFFER;
        end
      end
      OFFER: begin
        if (event_ready) begin
          clr          = {{(NUM_INPUTS-1){1'b0}}, 1'b1} << event_id_q;
          last_grant_d = event_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      event_id_q   <= '0;
      last_grant_q <= IDW'(NUM_INPUTS - 1);
    end else begin
      state_q      <= state_d;
      event_id_q   <= event_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign level       = stable_q;
  assign event_valid = (state_q == OFFER);
  assign event_id    = event_id_q;
  assign dropped     = dropped_q;

endmodule
